imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction words; SHALL be a power of two, at least 4.
REQ-002 Parameter NOP_WORD, default 32'h00000013, fill value written into every word during clear.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_addr  input  32  byte address of the requested instruction.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 rsp_valid  output  1  response word held on rsp_instr/rsp_err.
REQ-009 rsp_instr  output  32  fetched instruction.
REQ-010 rsp_err  output  1  request was misaligned or out of range.
REQ-011 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-012 ld_en  input  1  program-load write strobe.
REQ-013 ld_addr  input  log2(DEPTH)  word index to load.
REQ-014 ld_data  input  32  instruction word to load.
REQ-015 busy  output  1  high while the clear sequence runs.

Function
REQ-016 FSM SHALL have two states: CLEAR and SERVE.
REQ-017 CLEAR: a word counter starts at 0, writes NOP_WORD to word[counter] each cycle, and increments by 1; at counter == DEPTH-1, after that write, the FSM SHALL go to SERVE. CLEAR lasts exactly DEPTH cycles.
REQ-018 In CLEAR: busy=1, req_ready=0, and ld_en SHALL be ignored.
REQ-019 In SERVE: busy=0; ld_en=1 writes ld_data to word[ld_addr] at the clock edge.
REQ-020 req_ready SHALL be (state==SERVE) && !ld_en && (!rsp_valid || rsp_ready); it is combinational.
REQ-021 A handshake is req_valid && req_ready at a clock edge; the response SHALL appear on the next cycle (latency 1) with rsp_valid=1.
REQ-022 rsp_err SHALL be 1 if req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH; in that case rsp_instr SHALL be NOP_WORD.
REQ-023 Otherwise rsp_instr SHALL equal word[req_addr[log2(DEPTH)+1:2]] as it stood before the accepting edge, and rsp_err=0.
REQ-024 rsp_valid, rsp_instr and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-025 If rsp_ready=1 and no new handshake occurs, rsp_valid SHALL clear at that edge.
REQ-026 If rsp_ready=1 and a new handshake occurs at the same edge, the new response SHALL replace the old with no idle cycle, sustaining one response per cycle.
REQ-027 A load to the word of a response already held in the output register SHALL NOT alter that response.
REQ-028 Memory contents SHALL persist across responses; only CLEAR and ld_en write memory.

Reset
REQ-029 With rst=1: state=CLEAR, counter=0, rsp_valid=0, rsp_instr=0, rsp_err=0, busy=1, req_ready=0.
REQ-030 An rst assertion during SERVE or mid-CLEAR SHALL abort any held response and restart CLEAR from word 0. After release the full DEPTH-cycle clear SHALL run.

Verification
REQ-031 Release rst, hold req_valid=1 -> busy=1 and req_ready=0 for exactly 64 cycles, then busy=0 and req_ready=1; a fetch at 0x0 returns 0x00000013 with rsp_err=0.
REQ-032 In SERVE, load ld_addr=2, ld_data=0x00500093, then fetch req_addr=0x8 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_instr=0x00500093, rsp_err=0.
REQ-033 Fetch req_addr=0x6, then 0x100 (DEPTH=64) -> both responses have rsp_err=1 and rsp_instr=0x00000013.
REQ-034 Hold rsp_ready=0 after one response -> req_ready=0 and the response stays stable for 5 cycles; raise rsp_ready with req_valid=1 -> back-to-back responses at 1 per cycle.
REQ-035 Hold ld_en=1 while req_valid=1 in SERVE -> req_ready=0 throughout; after ld_en drops, the pending fetch is accepted and returns the loaded word.
REQ-036 Assert rst for 1 cycle while rsp_valid=1 -> rsp_valid=0 immediately (asynchronous), busy=1, and the previously loaded words read 0x00000013 after the re-clear.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction memory that answers fetch requests.
//
// After reset the memory is filled with NOP_WORD over DEPTH cycles (CLEAR).
// It then enters SERVE, where fetches are answered with one cycle of latency
// and words can be written through the program-load port.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  fetch request present
//   req_addr   byte address of the requested instruction
//   req_ready  request accepted this cycle (combinational)
//   rsp_valid  response held on rsp_instr / rsp_err
//   rsp_instr  fetched instruction (NOP_WORD on error)
//   rsp_err    request was misaligned or out of range
//   rsp_ready  consumer takes the response this cycle
//   ld_en      program-load write strobe (ignored during CLEAR)
//   ld_addr    word index to load
//   ld_data    instruction word to load
//   busy       high while the clear sequence runs
//
// DEPTH must be a power of two and at least 4.
//
// state | meaning
// ------+--------------------------------------------------------
// CLEAR | write NOP_WORD to word[counter], one word per cycle
// SERVE | answer fetches, accept program loads

module imem_responder #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_instr,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_busy;
  logic            w_clr_we;
  logic            w_ld_we;

  logic [31:0]     r_mem [DEPTH];

  logic            r_rsp_valid;
  logic [31:0]     r_rsp_instr;
  logic            r_rsp_err;

  logic            w_misal;
  logic            w_oob;
  logic [AW-1:0]   w_word;
  logic            w_req_ready;
  logic            w_hs;

  // State register and clear counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter wraps from DEPTH-1 back to 0 on the last clear write, so it is
  // already at 0 for the next clear.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    w_clr_we    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_busy    = 1'b1;
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        w_state_nxt = SERVE;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  assign w_ld_we = (r_state == SERVE) && ld_en;

  // Memory array, no reset: contents are rebuilt by CLEAR. While rst is held
  // the FSM sits in CLEAR with counter 0, so word 0 is merely rewritten with
  // NOP_WORD, which the subsequent clear does anyway.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= NOP_WORD;
    end else if (w_ld_we) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  // Address decode: any set bit above the word index means out of range.
  assign w_misal = |req_addr[1:0];
  assign w_oob   = |req_addr[31:AW+2];
  assign w_word  = req_addr[AW+1:2];

  // A pending load blocks acceptance, so a fetch never shares an edge with
  // a memory write.
  assign w_req_ready = (r_state == SERVE) && !ld_en && (!r_rsp_valid || rsp_ready);
  assign w_hs        = req_valid && w_req_ready;

  // Response register: captured at the accepting edge, so later loads to
  // the same word leave a held response untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_misal || w_oob;
      r_rsp_instr <= (w_misal || w_oob) ? NOP_WORD : r_mem[w_word];
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_instr = r_rsp_instr;
  assign rsp_err   = r_rsp_err;
  assign busy      = w_busy;

endmodule
